// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: FSM state encoding,
// field widths and the active-high gfedcba hex glyph table.
package seven_seg_pkg;

    localparam int SEG_W    = 7;
    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    // Entry n is the glyph for hex digit n, listed F down to 0.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seven_seg_scan_driver_hex_to_seg.sv
// Combinational hex nibble to active-high {g,f,e,d,c,b,a} glyph.
// Ports: nibble (4-bit hex digit in), seg (7-bit glyph out).
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with double-buffered value,
// frame-aligned Load/LoadAck handshake and one blank cycle between digits.
// Ports: Clk, Rst (async, active-high), Tick (advance strobe), Enable,
//   Value/DpIn (nibbles and decimal points, digit 0 in the LSBs), Load;
//   outputs LoadAck, An, Seg {g..a}, Dp, FrameDone (all registered).
// Optional: define SEVEN_SEG_LZ_BLANK_EN for leading-zero suppression.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Tick,
    input  logic                         Enable,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] Value,
    input  logic [NUM_DIGITS-1:0]        DpIn,
    input  logic                         Load,
    output logic                         LoadAck,
    output logic [NUM_DIGITS-1:0]        An,
    output logic [SEG_W-1:0]             Seg,
    output logic                         Dp,
    output logic                         FrameDone
);

    localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int   VAL_W = NIBBLE_W * NUM_DIGITS;
    localparam logic INV   = (ACTIVE_LOW != 0);

    logic [1:0]            state;
    logic [IDX_W-1:0]      index;
    logic [VAL_W-1:0]      staging;
    logic [NUM_DIGITS-1:0] staging_dp;
    logic [VAL_W-1:0]      display;
    logic [NUM_DIGITS-1:0] display_dp;
    logic                  pending;

    logic                  last;
    logic                  wrap;
    logic                  frame_start;
    logic                  transfer;
    logic [NIBBLE_W-1:0]   nibble;
    logic [SEG_W-1:0]      seg_raw;
    logic [SEG_W-1:0]      seg_on;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  lz_blank;

    assign last = (index == IDX_W'(NUM_DIGITS - 1));
    assign wrap = Enable && (state == ST_DRIVE) && Tick && last;

    // Leaving OFF counts as a frame start, so a load queued while dark
    // lands before the first digit is shown.
    assign frame_start = wrap || (Enable && (state == ST_OFF));
    assign transfer    = frame_start && (pending || Load);

    assign nibble = display[NIBBLE_W*int'(index) +: NIBBLE_W];
    assign onehot = NUM_DIGITS'(1) << index;

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (seg_raw)
    );

`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  upper_zero;

    // A digit is a leading zero when it and every higher digit are zero;
    // digit 0 is left out so a zero value still shows "0".
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero &&
                (display[i*NIBBLE_W +: NIBBLE_W] == '0);
            lz_mask[i] = upper_zero;
        end
    end

    assign lz_blank = lz_mask[index];
`else
    assign lz_blank = 1'b0;
`endif

    assign seg_on = lz_blank ? '0 : seg_raw;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= ST_OFF;
            index     <= '0;
            FrameDone <= 1'b0;
        end else begin
            FrameDone <= wrap;
            if (!Enable) begin
                state <= ST_OFF;
                index <= '0;
            end else begin
                unique case (state)
                    ST_OFF:   state <= ST_BLANK;
                    ST_BLANK: state <= ST_DRIVE;
                    ST_DRIVE: begin
                        if (Tick) begin
                            state <= ST_BLANK;
                            index <= last ? '0 : index + IDX_W'(1);
                        end
                    end
                    default:  state <= ST_OFF;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            staging    <= '0;
            staging_dp <= '0;
            display    <= '0;
            display_dp <= '0;
            pending    <= 1'b0;
            LoadAck    <= 1'b0;
        end else begin
            LoadAck <= transfer;
            if (Load) begin
                staging    <= Value;
                staging_dp <= DpIn;
            end
            if (transfer) begin
                display    <= Load ? Value : staging;
                display_dp <= Load ? DpIn : staging_dp;
                pending    <= 1'b0;
            end else if (Load) begin
                pending <= 1'b1;
            end
        end
    end

    // Enable is folded in so the display goes dark on the very next cycle
    // rather than waiting for the OFF state to propagate.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            An  <= {NUM_DIGITS{INV}};
            Seg <= {SEG_W{INV}};
            Dp  <= INV;
        end else if (Enable && (state == ST_DRIVE)) begin
            An  <= onehot ^ {NUM_DIGITS{INV}};
            Seg <= seg_on ^ {SEG_W{INV}};
            Dp  <= display_dp[index] ^ INV;
        end else begin
            An  <= {NUM_DIGITS{INV}};
            Seg <= {SEG_W{INV}};
            Dp  <= INV;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (8 digits, active-low).
// Expected outputs are queued per cycle and compared after each clock edge.
module tb_seven_seg_scan_driver;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Tick;
    logic        Enable;
    logic [31:0] Value;
    logic [7:0]  DpIn;
    logic        Load;
    logic        LoadAck;
    logic [7:0]  An;
    logic [6:0]  Seg;
    logic        Dp;
    logic        FrameDone;

    int compared   = 0;
    int mismatched = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS (8),
        .ACTIVE_LOW (1)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Tick      (Tick),
        .Enable    (Enable),
        .Value     (Value),
        .DpIn      (DpIn),
        .Load      (Load),
        .LoadAck   (LoadAck),
        .An        (An),
        .Seg       (Seg),
        .Dp        (Dp),
        .FrameDone (FrameDone)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] nib;
        logic       dp;
        logic [6:0] seg;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ack;
        logic       fd;
    } exp_t;

    vec_t vt[16];
    exp_t sbq[$];

    function automatic logic [6:0] seg_of(logic [31:0] v, int d);
        logic [3:0] n;
        logic [6:0] s;
        n = v[d*4 +: 4];
        s = vt[n].seg;
`ifdef SEVEN_SEG_LZ_BLANK_EN
        if (d != 0 && (v >> (4*d)) == 32'h0) s = 7'h00;
`endif
        return s;
    endfunction

    task automatic push_drv(string nm, int d, logic [31:0] v,
                            logic [7:0] p, logic ack, logic fd);
        exp_t e;
        e.name = nm;
        e.an   = ~(8'h01 << d);
        e.seg  = ~seg_of(v, d);
        e.dp   = ~p[d];
        e.ack  = ack;
        e.fd   = fd;
        sbq.push_back(e);
    endtask

    task automatic push_off(string nm, logic ack, logic fd);
        exp_t e;
        e.name = nm;
        e.an   = 8'hFF;
        e.seg  = 7'h7F;
        e.dp   = 1'b1;
        e.ack  = ack;
        e.fd   = fd;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check();
        exp_t e;
        compared++;
        if (sbq.size() == 0) begin
            mismatched++;
            $display("FAIL scoreboard_empty: got An=%b, want a queued entry", An);
        end else begin
            e = sbq.pop_front();
            if (An !== e.an || Seg !== e.seg || Dp !== e.dp ||
                LoadAck !== e.ack || FrameDone !== e.fd) begin
                mismatched++;
                $display("FAIL %s: got An=%b Seg=%h Dp=%b LoadAck=%b FrameDone=%b, want An=%b Seg=%h Dp=%b LoadAck=%b FrameDone=%b",
                         e.name, An, Seg, Dp, LoadAck, FrameDone,
                         e.an, e.seg, e.dp, e.ack, e.fd);
            end
        end
    endtask

    task automatic cyc_drv(string nm, int d, logic [31:0] v,
                           logic [7:0] p, logic ack, logic fd);
        push_drv(nm, d, v, p, ack, fd);
        step();
        check();
    endtask

    task automatic cyc_off(string nm, logic ack, logic fd);
        push_off(nm, ack, fd);
        step();
        check();
    endtask

    // Tick while digit d is shown; vn/pn is what the display holds after
    // a wrap. Any Load the caller raised is dropped after the tick edge.
    task automatic tick(int d, logic [31:0] vo, logic [7:0] po,
                        logic [31:0] vn, logic [7:0] pn, logic ack);
        int nd;
        nd = (d == 7) ? 0 : d + 1;
        Tick = 1'b1;
        cyc_drv($sformatf("tick_d%0d", d), d, vo, po, ack, d == 7);
        Tick = 1'b0;
        Load = 1'b0;
        cyc_off($sformatf("blank_after_d%0d", d), 1'b0, 1'b0);
        for (int k = 0; k < 6; k++)
            cyc_drv($sformatf("show_d%0d", nd), nd,
                    (d == 7) ? vn : vo, (d == 7) ? pn : po, 1'b0, 1'b0);
    endtask

    task automatic load_now(int d, logic [31:0] vs, logic [7:0] ps,
                            logic [31:0] lv, logic [7:0] lp);
        Value = lv;
        DpIn  = lp;
        Load  = 1'b1;
        cyc_drv($sformatf("load_at_d%0d", d), d, vs, ps, 1'b0, 1'b0);
        Load  = 1'b0;
    endtask

    task automatic start(logic [31:0] v, logic [7:0] p);
        Rst    = 1'b1;
        Enable = 1'b0;
        Load   = 1'b0;
        Tick   = 1'b0;
        cyc_off("start_rst", 1'b0, 1'b0);
        Rst    = 1'b0;
        Value  = v;
        DpIn   = p;
        Load   = 1'b1;
        Enable = 1'b1;
        cyc_off("start_ack", 1'b1, 1'b0);
        Load   = 1'b0;
        cyc_off("start_blank", 1'b0, 1'b0);
        repeat (3) cyc_drv("start_d0", 0, v, p, 1'b0, 1'b0);
    endtask

    localparam logic [31:0] VA = 32'h01234567;
    localparam logic [31:0] VB = 32'hDEADBEEF;
    localparam logic [31:0] VC = 32'h11111111;
    localparam logic [31:0] VD = 32'h22222222;
    localparam logic [31:0] VE = 32'h9ABCDEF5;
    localparam logic [31:0] VL = 32'h00000400;
    localparam logic [31:0] VF = 32'h76543210;
    localparam logic [7:0]  PA = 8'hA5;
    localparam logic [7:0]  PB = 8'h3C;
    localparam logic [7:0]  PC = 8'h0F;
    localparam logic [7:0]  PD = 8'hF0;
    localparam logic [7:0]  PE = 8'h55;
    localparam logic [7:0]  PL = 8'h02;
    localparam logic [7:0]  PF = 8'h81;

    initial begin
        #500000;
        $display("FAIL watchdog: run still going at 500000, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        vt[0]  = '{4'h0, 1'b0, 7'h3F};
        vt[1]  = '{4'h1, 1'b1, 7'h06};
        vt[2]  = '{4'h2, 1'b0, 7'h5B};
        vt[3]  = '{4'h3, 1'b1, 7'h4F};
        vt[4]  = '{4'h4, 1'b0, 7'h66};
        vt[5]  = '{4'h5, 1'b1, 7'h6D};
        vt[6]  = '{4'h6, 1'b0, 7'h7D};
        vt[7]  = '{4'h7, 1'b1, 7'h07};
        vt[8]  = '{4'h8, 1'b0, 7'h7F};
        vt[9]  = '{4'h9, 1'b1, 7'h6F};
        vt[10] = '{4'hA, 1'b0, 7'h77};
        vt[11] = '{4'hB, 1'b1, 7'h7C};
        vt[12] = '{4'hC, 1'b0, 7'h39};
        vt[13] = '{4'hD, 1'b1, 7'h5E};
        vt[14] = '{4'hE, 1'b0, 7'h79};
        vt[15] = '{4'hF, 1'b1, 7'h71};

        Rst    = 1'b1;
        Tick   = 1'b0;
        Enable = 1'b0;
        Value  = 32'h0;
        DpIn   = 8'h0;
        Load   = 1'b0;
        cyc_off("reset_state", 1'b0, 1'b0);
        cyc_off("reset_hold", 1'b0, 1'b0);

        // Hex decode table on digit 0.
        for (int i = 0; i < 16; i++) begin
            Rst    = 1'b1;
            Enable = 1'b0;
            cyc_off($sformatf("dec_rst_%0d", i), 1'b0, 1'b0);
            Rst    = 1'b0;
            Value  = {28'h0, vt[i].nib};
            DpIn   = {7'h0, vt[i].dp};
            Load   = 1'b1;
            Enable = 1'b1;
            cyc_off($sformatf("dec_ack_%0d", i), 1'b1, 1'b0);
            Load   = 1'b0;
            cyc_off($sformatf("dec_blank_%0d", i), 1'b0, 1'b0);
            e.name = $sformatf("dec_glyph_%0d", i);
            e.an   = 8'hFE;
            e.seg  = ~vt[i].seg;
            e.dp   = ~vt[i].dp;
            e.ack  = 1'b0;
            e.fd   = 1'b0;
            sbq.push_back(e);
            step();
            check();
        end

        // Plain scan of one full frame.
        start(VA, PA);
        for (int d = 0; d < 8; d++)
            tick(d, VA, PA, VA, PA, 1'b0);

        // Mid-frame load shows only after the wrap.
        for (int d = 0; d < 8; d++) begin
            if (d == 3) load_now(3, VA, PA, VB, PB);
            tick(d, VA, PA, VB, PB, d == 7);
        end

        // Two loads in one frame: last writer wins, one ack.
        for (int d = 0; d < 8; d++) begin
            if (d == 2) load_now(2, VB, PB, VC, PC);
            if (d == 5) load_now(5, VB, PB, VD, PD);
            tick(d, VB, PB, VD, PD, d == 7);
        end

        // Load coinciding with the wrap tick.
        for (int d = 0; d < 8; d++) begin
            if (d == 7) begin
                Value = VE;
                DpIn  = PE;
                Load  = 1'b1;
            end
            tick(d, VD, PD, VE, PE, d == 7);
        end

        // Mostly-zero value, then a full frame of it.
        for (int d = 0; d < 8; d++) begin
            if (d == 7) begin
                Value = VL;
                DpIn  = PL;
                Load  = 1'b1;
            end
            tick(d, VE, PE, VL, PL, d == 7);
        end
        for (int d = 0; d < 8; d++)
            tick(d, VL, PL, VL, PL, 1'b0);

        // Enable dropped while digit 5 is driven, load queued while dark.
        for (int d = 0; d < 5; d++)
            tick(d, VL, PL, VL, PL, 1'b0);
        Enable = 1'b0;
        cyc_off("en_drop", 1'b0, 1'b0);
        cyc_off("en_off", 1'b0, 1'b0);
        Value = VF;
        DpIn  = PF;
        Load  = 1'b1;
        cyc_off("off_load", 1'b0, 1'b0);
        Load  = 1'b0;
        cyc_off("off_pending", 1'b0, 1'b0);
        Enable = 1'b1;
        cyc_off("reen_ack", 1'b1, 1'b0);
        cyc_off("reen_blank", 1'b0, 1'b0);
        repeat (3) cyc_drv("reen_d0", 0, VF, PF, 1'b0, 1'b0);

        // Asynchronous reset with a load pending.
        tick(0, VF, PF, VF, PF, 1'b0);
        tick(1, VF, PF, VF, PF, 1'b0);
        load_now(2, VF, PF, 32'hCAFE1234, 8'hFF);
        #2;
        Rst = 1'b1;
        #1;
        push_off("rst_async", 1'b0, 1'b0);
        check();
        cyc_off("rst_hold", 1'b0, 1'b0);
        Rst = 1'b0;
        cyc_off("post_rst_boot", 1'b0, 1'b0);
        cyc_off("post_rst_blank", 1'b0, 1'b0);
        repeat (3) cyc_drv("post_rst_d0", 0, 32'h0, 8'h0, 1'b0, 1'b0);
        tick(0, 32'h0, 8'h0, 32'h0, 8'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
